// File: rtl/rob_if.sv
// rob_if: decode / writeback / commit bundle for the reorder buffer.
//   Decode side    : tag_token, alloc_rd, alloc_op -> rob ; avail_tag, full <- rob
//   Writeback side : wb_tag, wb_data, flush        -> rob
//   Commit side    : commit_valid, commit_tag, commit_rd, commit_op,
//                    commit_data, count            <- rob
// master is the environment (decode/writeback/regfile), slave is the rob.
interface rob_if #(
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int OP_W   = 6
);
  logic              tag_token;
  logic [REG_W-1:0]  alloc_rd;
  logic [OP_W-1:0]   alloc_op;
  logic [TAG_W-1:0]  avail_tag;
  logic              full;
  logic [TAG_W-1:0]  wb_tag;
  logic [DATA_W-1:0] wb_data;
  logic              flush;
  logic              commit_valid;
  logic [TAG_W-1:0]  commit_tag;
  logic [REG_W-1:0]  commit_rd;
  logic [OP_W-1:0]   commit_op;
  logic [DATA_W-1:0] commit_data;
  logic [TAG_W-1:0]  count;

  modport master (
    output tag_token, alloc_rd, alloc_op, wb_tag, wb_data, flush,
    input  avail_tag, full, commit_valid, commit_tag, commit_rd,
           commit_op, commit_data, count
  );

  modport slave (
    input  tag_token, alloc_rd, alloc_op, wb_tag, wb_data, flush,
    output avail_tag, full, commit_valid, commit_tag, commit_rd,
           commit_op, commit_data, count
  );
endinterface

// File: rtl/rob.sv
// rob: circular reorder buffer between issue and in-order commit.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : rob_if.slave
//     tag_token/alloc_rd/alloc_op : allocation request from decode
//     avail_tag/full              : tag offered this cycle / no free entry
//     wb_tag/wb_data              : result writeback (all-ones tag = none)
//     flush                       : synchronous discard of all entries
//     commit_*                    : one-cycle retire pulse plus held fields
//     count                       : occupied entries, 0..DEPTH
module rob #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int OP_W   = 6
) (
  input logic  clk,
  input logic  rst,
  rob_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [TAG_W-1:0] TAG_INVALID = {TAG_W{1'b1}};
  localparam logic [TAG_W-1:0] DEPTH_T     = TAG_W'(DEPTH);
  localparam logic [TAG_W-1:0] CNT_ONE     = {{(TAG_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_ONE     = {{(PTR_W-1){1'b0}}, 1'b1};

  // Per-entry status (reset) and payload (not reset; only read when valid).
  logic [DEPTH-1:0]  valid_r;
  logic [DEPTH-1:0]  done_r;
  logic [REG_W-1:0]  rd_r   [DEPTH];
  logic [OP_W-1:0]   op_r   [DEPTH];
  logic [DATA_W-1:0] data_r [DEPTH];

  logic [PTR_W-1:0]  head_r;
  logic [PTR_W-1:0]  tail_r;
  logic [TAG_W-1:0]  count_r;

  logic              commit_valid_r;
  logic [TAG_W-1:0]  commit_tag_r;
  logic [REG_W-1:0]  commit_rd_r;
  logic [OP_W-1:0]   commit_op_r;
  logic [DATA_W-1:0] commit_data_r;

  logic              full_s;
  logic              alloc_s;
  logic              wb_hit_s;
  logic              commit_s;
  logic [PTR_W-1:0]  wb_idx_s;
  logic [TAG_W-1:0]  count_nxt_s;

  // Event decode from registered state: allocate, writeback hit, commit, next count.
  always_comb begin
    full_s   = (count_r == DEPTH_T);
    alloc_s  = bus.tag_token & ~full_s;
    wb_idx_s = bus.wb_tag[PTR_W-1:0];
    // The tag range check keeps out-of-range tags from aliasing onto a live entry.
    wb_hit_s = (bus.wb_tag != TAG_INVALID) && (bus.wb_tag < DEPTH_T) && valid_r[wb_idx_s];
    // Uses pre-edge done, so a writeback to head commits one edge later.
    commit_s = valid_r[head_r] & done_r[head_r];
    if (alloc_s && !commit_s) begin
      count_nxt_s = count_r + CNT_ONE;
    end else if (!alloc_s && commit_s) begin
      count_nxt_s = count_r - CNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Control state: entry status bits, pointers, occupancy and commit outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r        <= '0;
      done_r         <= '0;
      head_r         <= '0;
      tail_r         <= '0;
      count_r        <= '0;
      commit_valid_r <= 1'b0;
      commit_tag_r   <= TAG_INVALID;
      commit_rd_r    <= '0;
      commit_op_r    <= '0;
      commit_data_r  <= '0;
    end else if (bus.flush) begin
      // Flush wins over everything this edge; commit_* fields other than valid hold.
      valid_r        <= '0;
      done_r         <= '0;
      head_r         <= '0;
      tail_r         <= '0;
      count_r        <= '0;
      commit_valid_r <= 1'b0;
    end else begin
      // Allocate, writeback and commit target distinct entries: the tail slot
      // is never valid while allocating, and writeback only hits valid slots.
      if (wb_hit_s) begin
        done_r[wb_idx_s] <= 1'b1;
      end
      if (alloc_s) begin
        valid_r[tail_r] <= 1'b1;
        done_r[tail_r]  <= 1'b0;
        tail_r          <= tail_r + PTR_ONE;
      end
      if (commit_s) begin
        valid_r[head_r] <= 1'b0;
        head_r          <= head_r + PTR_ONE;
        commit_valid_r  <= 1'b1;
        commit_tag_r    <= {{(TAG_W-PTR_W){1'b0}}, head_r};
        commit_rd_r     <= rd_r[head_r];
        commit_op_r     <= op_r[head_r];
        commit_data_r   <= data_r[head_r];
      end else begin
        commit_valid_r  <= 1'b0;
      end
      count_r <= count_nxt_s;
    end
  end

  // Entry payload storage: destination/op on allocate, result on writeback.
  always_ff @(posedge clk) begin
    if (alloc_s && !bus.flush) begin
      rd_r[tail_r] <= bus.alloc_rd;
      op_r[tail_r] <= bus.alloc_op;
    end
    if (wb_hit_s && !bus.flush) begin
      data_r[wb_idx_s] <= bus.wb_data;
    end
  end

  assign bus.full         = full_s;
  assign bus.avail_tag    = full_s ? TAG_INVALID : {{(TAG_W-PTR_W){1'b0}}, tail_r};
  assign bus.count        = count_r;
  assign bus.commit_valid = commit_valid_r;
  assign bus.commit_tag   = commit_tag_r;
  assign bus.commit_rd    = commit_rd_r;
  assign bus.commit_op    = commit_op_r;
  assign bus.commit_data  = commit_data_r;
endmodule

// File: tb/tb_rob.sv
// tb_rob: directed stimulus for rob; expected commits go into a scoreboard
// queue tagged with the clock edge they must appear on, and a monitor pops
// and compares every commit pulse.
module tb_rob;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   edge_n = 0;
  int   tests = 0;
  int   fails = 0;

  typedef struct {
    logic [3:0]  tag;
    logic [4:0]  rd;
    logic [5:0]  op;
    logic [31:0] data;
    int          edge_no;
  } exp_t;
  exp_t q[$];

  rob_if #(.TAG_W(4), .DATA_W(32), .REG_W(5), .OP_W(6)) bus ();

  rob #(.DEPTH(8), .TAG_W(4), .DATA_W(32), .REG_W(5), .OP_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Edge counter used to time-stamp expected commits.
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] tag, input logic [4:0] rd, input logic [5:0] op,
                      input logic [31:0] data, input int edge_no);
    exp_t e;
    e.tag = tag; e.rd = rd; e.op = op; e.data = data; e.edge_no = edge_no;
    q.push_back(e);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Monitor: every commit pulse must match the oldest expected entry.
  always @(posedge clk) begin
    #1;
    if (bus.commit_valid === 1'b1) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_commit: got tag %0h data %0h, expected no commit (t=%0t)",
                 bus.commit_tag, bus.commit_data, $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("commit_tag",  32'(bus.commit_tag), 32'(e.tag));
        chk("commit_rd",   32'(bus.commit_rd),  32'(e.rd));
        chk("commit_op",   32'(bus.commit_op),  32'(e.op));
        chk("commit_data", bus.commit_data,     e.data);
        chk("commit_edge", 32'(edge_n),         32'(e.edge_no));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.tag_token = 1'b0;
    bus.alloc_rd  = 5'd0;
    bus.alloc_op  = 6'd0;
    bus.wb_tag    = 4'hF;
    bus.wb_data   = 32'h0;
    bus.flush     = 1'b0;

    // Reset values
    cyc(); cyc();
    chk("rst_avail", 32'(bus.avail_tag), 32'h0);
    chk("rst_full",  32'(bus.full), 32'h0);
    chk("rst_count", 32'(bus.count), 32'h0);
    chk("rst_cv",    32'(bus.commit_valid), 32'h0);
    chk("rst_ctag",  32'(bus.commit_tag), 32'hF);
    rst = 1'b1;
    cyc();

    // Three allocations, tags 0,1,2
    for (int i = 0; i < 3; i++) begin
      bus.tag_token = 1'b1;
      bus.alloc_rd  = 5'(i + 1);
      bus.alloc_op  = 6'(8'h11 + i);
      chk("alloc_tag", 32'(bus.avail_tag), 32'(i));
      cyc();
    end
    bus.tag_token = 1'b0;
    chk("count3", 32'(bus.count), 32'd3);
    chk("full3",  32'(bus.full), 32'd0);

    // Out-of-order writebacks retire in order
    push(4'd0, 5'd1, 6'h11, 32'h00A, edge_n + 3);
    push(4'd1, 5'd2, 6'h12, 32'h011, edge_n + 4);
    push(4'd2, 5'd3, 6'h13, 32'h022, edge_n + 5);
    bus.wb_tag = 4'd2; bus.wb_data = 32'h22; cyc();
    bus.wb_tag = 4'd0; bus.wb_data = 32'h0A; cyc();
    bus.wb_tag = 4'd1; bus.wb_data = 32'h11; cyc();
    bus.wb_tag = 4'hF;
    cyc(); cyc(); cyc();
    chk("order_drained", 32'(q.size()), 32'd0);
    chk("order_count",   32'(bus.count), 32'd0);

    // Fill, reject when full, wrap after commit
    bus.flush = 1'b1; cyc(); bus.flush = 1'b0;
    chk("flush_avail0", 32'(bus.avail_tag), 32'd0);
    for (int i = 0; i < 8; i++) begin
      bus.tag_token = 1'b1;
      bus.alloc_rd  = 5'(i + 8);
      bus.alloc_op  = 6'(i + 32);
      chk("fill_tag", 32'(bus.avail_tag), 32'(i));
      cyc();
    end
    chk("full_flag",  32'(bus.full), 32'd1);
    chk("full_avail", 32'(bus.avail_tag), 32'hF);
    cyc();
    bus.tag_token = 1'b0;
    chk("full_ignore_count", 32'(bus.count), 32'd8);
    bus.wb_tag = 4'd0; bus.wb_data = 32'hA0;
    push(4'd0, 5'd8, 6'd32, 32'hA0, edge_n + 2);
    cyc();
    bus.wb_tag = 4'hF;
    chk("full_during_commit", 32'(bus.full), 32'd1);
    bus.tag_token = 1'b1; bus.alloc_rd = 5'h1F;
    cyc();
    bus.tag_token = 1'b0;
    chk("after_commit_full",  32'(bus.full), 32'd0);
    chk("after_commit_avail", 32'(bus.avail_tag), 32'd0);
    chk("after_commit_count", 32'(bus.count), 32'd7);

    // Dropped writebacks: same-edge allocate, unallocated, invalid, out-of-range
    bus.flush = 1'b1; cyc(); bus.flush = 1'b0;
    bus.tag_token = 1'b1; bus.alloc_rd = 5'd1; bus.alloc_op = 6'd1; cyc();
    bus.alloc_rd = 5'd2; bus.alloc_op = 6'd2; cyc();
    bus.alloc_rd = 5'd3; bus.alloc_op = 6'd3;
    bus.wb_tag = 4'd2; bus.wb_data = 32'h55; cyc();
    bus.tag_token = 1'b0;
    bus.wb_tag = 4'd5; bus.wb_data = 32'h66; cyc();
    bus.wb_tag = 4'hF; bus.wb_data = 32'h77; cyc();
    bus.wb_tag = 4'd8; bus.wb_data = 32'h88; cyc();
    bus.wb_tag = 4'hF; cyc();
    chk("drop_count", 32'(bus.count), 32'd3);
    bus.wb_tag = 4'd0; bus.wb_data = 32'h100;
    push(4'd0, 5'd1, 6'd1, 32'h100, edge_n + 2);
    cyc();
    bus.wb_tag = 4'd1; bus.wb_data = 32'h101;
    push(4'd1, 5'd2, 6'd2, 32'h101, edge_n + 2);
    cyc();
    bus.wb_tag = 4'hF; cyc(); cyc();
    chk("same_edge_wb_dropped", 32'(bus.count), 32'd1);
    chk("drop_drained", 32'(q.size()), 32'd0);

    // Flush with four outstanding, two done
    for (int i = 0; i < 3; i++) begin
      bus.tag_token = 1'b1;
      bus.alloc_rd  = 5'(i + 4);
      bus.alloc_op  = 6'(i + 4);
      chk("pre_flush_tag", 32'(bus.avail_tag), 32'(i + 3));
      cyc();
    end
    bus.tag_token = 1'b0;
    bus.wb_tag = 4'd4; bus.wb_data = 32'h44; cyc();
    bus.wb_tag = 4'd5; bus.wb_data = 32'h45; cyc();
    chk("pre_flush_count", 32'(bus.count), 32'd4);
    bus.flush = 1'b1; bus.tag_token = 1'b1; bus.wb_tag = 4'd2; bus.wb_data = 32'h99;
    cyc();
    bus.flush = 1'b0; bus.tag_token = 1'b0; bus.wb_tag = 4'hF;
    chk("flush_cv",    32'(bus.commit_valid), 32'd0);
    chk("flush_count", 32'(bus.count), 32'd0);
    chk("flush_avail", 32'(bus.avail_tag), 32'd0);
    bus.wb_tag = 4'd4; bus.wb_data = 32'h77; cyc();
    bus.wb_tag = 4'hF;
    chk("post_flush_wb_count", 32'(bus.count), 32'd0);
    bus.tag_token = 1'b1; bus.alloc_rd = 5'd9; bus.alloc_op = 6'd9;
    chk("post_flush_tag", 32'(bus.avail_tag), 32'd0);
    cyc();
    bus.tag_token = 1'b0;
    cyc(); cyc();
    chk("post_flush_no_commit", 32'(bus.count), 32'd1);

    // Asynchronous reset while a commit pulse is high
    bus.wb_tag = 4'd0; bus.wb_data = 32'hDEAD;
    push(4'd0, 5'd9, 6'd9, 32'hDEAD, edge_n + 2);
    cyc();
    bus.wb_tag = 4'hF;
    cyc();
    chk("pre_rst_cv", 32'(bus.commit_valid), 32'd1);
    rst = 1'b0;
    #1;
    chk("async_cv",    32'(bus.commit_valid), 32'd0);
    chk("async_ctag",  32'(bus.commit_tag), 32'hF);
    chk("async_crd",   32'(bus.commit_rd), 32'd0);
    chk("async_cop",   32'(bus.commit_op), 32'd0);
    chk("async_cdata", bus.commit_data, 32'd0);
    chk("async_count", 32'(bus.count), 32'd0);
    chk("async_avail", 32'(bus.avail_tag), 32'd0);
    chk("async_full",  32'(bus.full), 32'd0);
    cyc();
    rst = 1'b1;
    cyc(); cyc();
    chk("end_count", 32'(bus.count), 32'd0);
    chk("end_drained", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rob.md
# rob

Reorder buffer holding in-flight instructions between issue and architectural commit. It answers the decode stage's tag requests by allocating entries in a circular buffer, absorbing results from the writeback bus, and retiring completed entries strictly in program order toward the register file. It is the responder end of the decode stage's ROB-position handshake: `avail_tag`, `full`, `tag_token`, `rd` and `op`.

## Interface
- DEPTH, 8: number of entries. Must be a power of two, ≥2.
- TAG_W, 4: tag width. Must satisfy 2^TAG_W > DEPTH; all-ones is TAG_INVALID and is never allocated.
- DATA_W, 32: result width.
- REG_W, 5: architectural register index width.
- OP_W, 6: op-type width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- tag_token  in  1  allocation request from decode.
- alloc_rd  in  REG_W  destination register of the requesting instruction.
- alloc_op  in  OP_W  op type of the requesting instruction.
- avail_tag  out  TAG_W  tag granted if tag_token is high this cycle; TAG_INVALID when full.
- full  out  1  no free entry.
- wb_tag  in  TAG_W  writeback tag; TAG_INVALID means no writeback.
- wb_data  in  DATA_W  writeback value.
- flush  in  1  discard all entries (mispredict or jump recovery).
- commit_valid  out  1  one-cycle pulse: the commit_* fields are valid.
- commit_tag  out  TAG_W  tag of the retired entry.
- commit_rd  out  REG_W  destination of the retired entry.
- commit_op  out  OP_W  op of the retired entry.
- commit_data  out  DATA_W  result of the retired entry.
- count  out  TAG_W  number of occupied entries, 0..DEPTH.

## Operation
- Per-entry state: valid, done, rd, op, data.
- Pointers: head (oldest) and tail (next free), both log2(DEPTH) bits. They wrap modulo DEPTH by natural overflow.
- avail_tag and full are combinational from registered state only: `full = (count == DEPTH)`, `avail_tag = full ? TAG_INVALID : tail` (zero-extended).
- Allocate: on a rising edge with tag_token=1 and full=0:
  - entry[tail] gets valid=1, done=0, rd=alloc_rd, op=alloc_op.
  - tail increments.
  - tag_token while full is ignored; nothing changes.
- Writeback: on a rising edge, if wb_tag≠TAG_INVALID, wb_tag<DEPTH, and entry[wb_tag].valid=1, then done=1 and data=wb_data.
  - A writeback to an invalid entry, including the entry being allocated on the same edge, is dropped.
  - A repeated writeback overwrites data.
- Commit: on a rising edge, if entry[head].valid and entry[head].done were set before the edge:
  - commit_valid<=1 and commit_* <= entry[head] fields.
  - entry[head].valid<=0 and head increments.
  - Otherwise commit_valid<=0; the other commit_* outputs hold their values.
  - At most one commit per cycle.
  - rd=0 entries commit normally; the register file ignores them.
- Count: next count = count + allocate − commit. Simultaneous allocate and commit leaves count unchanged.
- Flush is synchronous and has highest priority. On an edge with flush=1:
  - all valid<=0; head, tail and count <= 0; commit_valid<=0.
  - Any allocate, writeback or commit in that cycle is suppressed.
- Reset (rst=0, asynchronous):
  - all valid/done=0; head, tail and count =0.
  - commit_valid=0, commit_tag=TAG_INVALID, commit_rd=0, commit_op=0, commit_data=0.
  - Therefore avail_tag=0 and full=0 while in reset.
  - Reset asserted mid-operation discards everything immediately.

## Timing
- Allocation: the tag is visible combinationally in the cycle of the request. The entry is occupied from the following edge.
- Writeback to commit: a writeback landing at edge N on the head entry produces commit_valid high after edge N+1, so the minimum latency is 1 cycle.
- A full ROB stays full in any cycle where it also commits. full drops one cycle after the commit edge, so a request made that cycle is rejected and decode stalls.
- Back-to-back: one allocate, one writeback and one commit can all happen on the same edge on distinct entries.
- Wrap: after tag DEPTH−1 is allocated, the next avail_tag is 0.

## Test plan
- Reset then 3 requests (rd=1,2,3) on consecutive cycles -> avail_tag 0,1,2; count=3; full=0; no commit.
- Writebacks tag2=0x22, tag0=0x00A, tag1=0x11 on consecutive cycles -> commits in order tag0, tag1, tag2, one per cycle, each starting the cycle after its own entry and all older entries are done. Data 0x00A, 0x11, 0x22.
- Fill 8 entries -> full=1, avail_tag=4'hF. A further tag_token causes no change. Write back tag0 -> commit the next edge, then full=0 and avail_tag=0 (wrap).
- Write back to an unallocated tag 5, and to tag 4'hF -> no state change and no commit.
- 4 entries outstanding, 2 done, assert flush -> commit_valid=0 next cycle, count=0, avail_tag=0. A writeback of an old tag after the flush is dropped.
- Assert rst low mid-stream with commit_valid high -> all outputs take their reset values immediately, without waiting for a clock edge.
